// File: rtl/sb_io_in_ddr_deser_if.sv
// Output stream of the DDR input deserialiser: packed words with a
// valid/ready handshake.
interface sb_io_in_ddr_deser_if #(
    parameter int WIDTH = 8,
    parameter int PAIRS = 2,
    parameter int DEPTH = 4
);
    logic [2*PAIRS*WIDTH-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sb_io_in_ddr_deser.sv
// DDR input deserialiser for iCE40 pins: SB_IO registered-DDR capture, beat
// packing into 2*PAIRS*WIDTH-bit words, and a small valid/ready FIFO.
module sb_io_in_ddr_deser #(
    parameter int WIDTH = 8,
    parameter int PAIRS = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           pin,
    input  logic                       en,
    input  logic                       phase,
    sb_io_in_ddr_deser_if.master       out_if,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       clear_ovf
);
    localparam int WORD_W = 2 * PAIRS * WIDTH;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;

    // d0 is the rising-edge sample, d1 the following falling-edge sample.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
`ifdef SIM_SB_IO
        _SB_IO #(.PIN_TYPE(6'b000000), .PULLUP(1'b0)) u_io (
            .PACKAGE_PIN      (pin[i]),
            .LATCH_INPUT_VALUE(1'b0),
            .CLOCK_ENABLE     (1'b1),
            .INPUT_CLK        (clock),
            .OUTPUT_CLK       (clock),
            .OUTPUT_ENABLE    (1'b0),
            .D_OUT_0          (1'b0),
            .D_OUT_1          (1'b0),
            .D_IN_0           (d0[i]),
            .D_IN_1           (d1[i])
        );
`elsif SYNTHESIS
        SB_IO #(.PIN_TYPE(6'b000000), .PULLUP(1'b0)) u_io (
            .PACKAGE_PIN      (pin[i]),
            .LATCH_INPUT_VALUE(1'b0),
            .CLOCK_ENABLE     (1'b1),
            .INPUT_CLK        (clock),
            .OUTPUT_CLK       (clock),
            .OUTPUT_ENABLE    (1'b0),
            .D_OUT_0          (1'b0),
            .D_OUT_1          (1'b0),
            .D_IN_0           (d0[i]),
            .D_IN_1           (d1[i])
        );
`else
        logic rise_q;
        logic fall_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) rise_q <= 1'b0;
            else          rise_q <= pin[i];
        end

        always_ff @(negedge clock or negedge reset_n) begin
            if (!reset_n) fall_q <= 1'b0;
            else          fall_q <= pin[i];
        end

        assign d0[i] = rise_q;
        assign d1[i] = fall_q;
`endif
    end

    logic [WIDTH-1:0]   held_q, held_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [WORD_W-1:0]  mem_q [DEPTH];
    logic [WORD_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ovf_q, ovf_d;
    logic [2*WIDTH-1:0] pair;
    logic               word_done;
    logic               push;
    logic               pop;
    logic               full;

    always_comb begin
        held_d    = d1;
        phase_d   = en ? phase_q : phase;
        // Each pair lands as {B, A}; phase=1 pairs the previous falling beat with this rising one.
        pair      = phase_q ? {d0, held_q} : {d1, d0};
        count_d   = '0;
        word_d    = word_q;
        word_done = 1'b0;
        if (en) begin
            word_d[int'(count_q)*2*WIDTH +: 2*WIDTH] = pair;
            word_done = (count_q == CNT_W'(PAIRS - 1));
            count_d   = word_done ? '0 : count_q + CNT_W'(1);
        end

        full = (level_q == LVL_W'(DEPTH));
        pop  = out_if.out_ready && (level_q != '0);
        // A pop frees the slot in the same cycle, so a full FIFO still accepts.
        push = word_done && (!full || pop);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = word_d;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

        ovf_d = ovf_q;
        if (word_done && !push) ovf_d = 1'b1;
        else if (clear_ovf)     ovf_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            held_q   <= '0;
            phase_q  <= 1'b0;
            count_q  <= '0;
            word_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            held_q   <= held_d;
            phase_q  <= phase_d;
            count_q  <= count_d;
            word_q   <= word_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign out_if.out_data  = mem_q[rd_ptr_q];
    assign out_if.out_valid = (level_q != '0);
    assign level            = level_q;
    assign overflow         = ovf_q;
endmodule

// File: tb/tb_sb_io_in_ddr_deser.sv
// Scoreboard bench for sb_io_in_ddr_deser: a per-edge behavioural model pushes
// expected words into a queue; the FIFO head is compared every cycle.
module tb_sb_io_in_ddr_deser;
    localparam int WIDTH  = 8;
    localparam int PAIRS  = 2;
    localparam int DEPTH  = 4;
    localparam int WORD_W = 2 * PAIRS * WIDTH;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic [WIDTH-1:0]  pin = '0;
    logic              en = 1'b0;
    logic              phase = 1'b0;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              clear_ovf = 1'b0;

    sb_io_in_ddr_deser_if #(.WIDTH(WIDTH), .PAIRS(PAIRS), .DEPTH(DEPTH)) busIf ();

    sb_io_in_ddr_deser #(.WIDTH(WIDTH), .PAIRS(PAIRS), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .pin      (pin),
        .en       (en),
        .phase    (phase),
        .out_if   (busIf),
        .level    (level),
        .overflow (overflow),
        .clear_ovf(clear_ovf)
    );

    always #5 clock = ~clock;

    int                vectorCount = 0;
    int                missCount = 0;
    logic [WORD_W-1:0] expQ [$];
    logic [WIDTH-1:0]  prevRise = '0;
    logic [WIDTH-1:0]  prevFall = '0;
    logic [WIDTH-1:0]  modelHeld = '0;
    logic              modelPhase = 1'b0;
    logic              modelOvf = 1'b0;
    logic              pendEn = 1'b0;
    int                modelCount = 0;
    logic [WORD_W-1:0] modelWord = '0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkState();
        checkOutput("level", 64'(level), 64'(expQ.size()));
        checkOutput("out_valid", 64'(busIf.out_valid), 64'(expQ.size() != 0));
        checkOutput("overflow", 64'(overflow), 64'(modelOvf));
        if (expQ.size() != 0) checkOutput("head_data", 64'(busIf.out_data), 64'(expQ[0]));
    endtask

    // Expected effect of the coming rising edge, which consumes the pair
    // (prevRise, prevFall) captured during the previous cycle.
    task automatic modelEdge(input logic e, input logic ph, input logic ready, input logic clr);
        logic [WIDTH-1:0] a, b;
        logic done, pop, push;
        done = 1'b0;
        if (modelPhase) begin a = modelHeld; b = prevRise; end
        else            begin a = prevRise;  b = prevFall; end
        if (e) begin
            modelWord[2*WIDTH*modelCount +: 2*WIDTH] = {b, a};
            done = (modelCount == PAIRS - 1);
            modelCount = done ? 0 : modelCount + 1;
        end else begin
            modelCount = 0;
        end
        pop = ready && (expQ.size() != 0);
        if (pop) begin
            checkOutput("pop_data", 64'(busIf.out_data), 64'(expQ[0]));
            void'(expQ.pop_front());
        end
        push = done && (expQ.size() < DEPTH);
        if (push) expQ.push_back(modelWord);
        if (done && !push) modelOvf = 1'b1;
        else if (clr)      modelOvf = 1'b0;
        modelHeld = prevFall;
        if (!e) modelPhase = ph;
    endtask

    // Entered with clock low; r is the next rising beat, f the falling beat
    // after it, e the enable that will apply when this pair is consumed.
    task automatic applyStimulus(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] f,
                                 input logic e, input logic ready, input logic clr, input logic ph);
        checkState();
        pin = r;
        en = pendEn;
        busIf.out_ready = ready;
        clear_ovf = clr;
        phase = ph;
        modelEdge(pendEn, ph, ready, clr);
        @(posedge clock);
        #1 pin = f;
        @(negedge clock);
        #1;
        prevRise = r;
        prevFall = f;
        pendEn = e;
    endtask

    task automatic idle(input logic ready);
        applyStimulus('0, '0, 1'b0, ready, 1'b0, 1'b0);
    endtask

    task automatic applyReset();
        reset_n = 1'b0;
        #1;
        checkOutput("rst_valid", 64'(busIf.out_valid), 64'd0);
        checkOutput("rst_level", 64'(level), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
        checkOutput("rst_data", 64'(busIf.out_data), 64'd0);
        expQ.delete();
        modelCount = 0; modelHeld = '0; modelPhase = 1'b0; modelOvf = 1'b0;
        modelWord = '0; prevRise = '0; prevFall = '0; pendEn = 1'b0;
        en = 1'b0; pin = '0; clear_ovf = 1'b0; busIf.out_ready = 1'b0;
        @(negedge clock);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        busIf.out_ready = 1'b0;
        #2;
        applyReset();

        // Phase 0 packing of a single word.
        applyStimulus(8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h33, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("t1_word", 64'(busIf.out_data), 64'h44332211);
        checkOutput("t1_level", 64'(level), 64'd1);
        idle(1'b1);
        idle(1'b0);

        // Phase 1, preceded by a lone falling beat.
        applyStimulus(8'h00, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h33, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_word", 64'(busIf.out_data), 64'h332211AA);
        idle(1'b1);
        idle(1'b0);

        // Five words into a four-deep FIFO with no consumer.
        for (int w = 0; w < 5; w++) begin
            applyStimulus(8'(16*w + 1), 8'(16*w + 2), 1'b1, 1'b0, 1'b0, 1'b0);
            applyStimulus(8'(16*w + 3), 8'(16*w + 4), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle(1'b0);
        checkOutput("t3_level", 64'(level), 64'd4);
        checkOutput("t3_ovf", 64'(overflow), 64'd1);
        checkOutput("t3_head", 64'(busIf.out_data), 64'h04030201);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t3_clear", 64'(overflow), 64'd0);

        // Full FIFO: completing a word alongside a pop.
        applyStimulus(8'h81, 8'h82, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h83, 8'h84, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        checkOutput("t4_level", 64'(level), 64'd4);
        checkOutput("t4_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        checkOutput("t4_tail", 64'(busIf.out_data), 64'h84838281);
        idle(1'b1);
        idle(1'b0);

        // Partial word discarded on en drop; phase changes under en ignored.
        applyStimulus(8'h51, 8'h52, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h53, 8'h54, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h61, 8'h62, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h63, 8'h64, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_word", 64'(busIf.out_data), 64'h64636261);
        checkOutput("t5_level", 64'(level), 64'd1);
        idle(1'b1);
        idle(1'b0);

        // Reset with three words queued and a half-built word.
        for (int w = 0; w < 3; w++) begin
            applyStimulus(8'(16*w + 5), 8'(16*w + 6), 1'b1, 1'b0, 1'b0, 1'b0);
            applyStimulus(8'(16*w + 7), 8'(16*w + 8), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(8'h91, 8'h92, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t6_level", 64'(level), 64'd3);
        applyReset();
        applyStimulus(8'h71, 8'h72, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h73, 8'h74, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("t6_word", 64'(busIf.out_data), 64'h74737271);
        idle(1'b1);

        // Random traffic: enable, phase, ready and clear all varying.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        checkOutput("final_level", 64'(level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
